serial_addsub_unit: RTL and testbench
=====================================

Name: serial_addsub_unit

Overview:
Parametrised multi-cycle adder/subtractor. It processes WIDTH-bit operands LSB-first, STEP bits per clock, through a chained full add/subtract slice with a registered carry/borrow. It replaces fixed-width ripple subtractors where area matters more than latency. A start/done handshake lets it sit behind a simple controller or testbench driver. Besides the result, it reports carry/borrow, signed overflow and zero flags.

Parameters:
WIDTH, 6, operand and result width in bits; must be >= 2.
STEP, 1, bits processed per RUN cycle; WIDTH must be divisible by STEP; N = WIDTH/STEP.

Ports:
clk  input  1  rising-edge clock, sole clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
mode  input  1  0 = subtract (a - b), 1 = add (a + b); latched on start
a  input  WIDTH  operand A; latched on start
b  input  WIDTH  operand B; latched on start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result and flags valid
result  output  WIDTH  a - b or a + b, modulo 2^WIDTH
cb  output  1  add: carry out; sub: borrow out (1 iff a < b unsigned)
overflow  output  1  two's-complement signed overflow of the operation
zero  output  1  result == 0

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. busy, done, result, cb, overflow and zero are all 0. Working registers and step counter are cleared.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and outputs read 0 after release.
- States and transitions:
  - IDLE -> RUN on an edge with start=1. On that edge a, b and mode are latched into working registers, the step counter is set to 0, and the internal carry/borrow is set to 0.
  - RUN: each edge processes bits [STEP*k+STEP-1 : STEP*k] of the latched operands, k = step counter. The carry/borrow chains through the STEP slices within the cycle, and the final carry/borrow is registered for the next step.
  - RUN -> DONE on the edge that completes step N-1. On that edge result, cb, overflow and zero are loaded, and done goes to 1.
  - DONE -> IDLE on the next edge; done returns to 0.
- Latency: the start edge is edge 0, and done is high in the cycle after edge N. Throughput is one operation per N+2 cycles.
- busy = 1 exactly in RUN (N cycles). done = 1 exactly in DONE (1 cycle).
- start is ignored in RUN and DONE. It is not queued, and operand inputs may change freely outside IDLE.
- Output registers are loaded only on the RUN->DONE edge. They hold their values through IDLE and the whole next RUN until the next DONE, so partial results are never visible on result.
- Arithmetic per bit:
  - Subtract: d = x ^ y ^ bi; bo = (~x & y) | (~(x ^ y) & bi).
  - Add: s = x ^ y ^ ci; co = (x & y) | ((x ^ y) & ci).
- Flags:
  - cb is the chain value out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry/borrow out of MSB, computed on the last step.
  - zero is computed from the complete result.
- If start and reset release coincide, reset dominates while rst_n is low. The first start sampled after release is honoured.

Test Plan:
- WIDTH=6, STEP=1, sub, a=001010 b=000100 -> done 6 cycles after start edge; result=000110, cb=0, overflow=0, zero=0; busy high for exactly 6 cycles.
- Sub a=000001 b=000010 -> result=111111, cb=1, overflow=0. Then sub a=000001 b=000001 -> result=000000, zero=1, cb=0.
- Sub a=100000 b=000001 -> result=011111, cb=0, overflow=1. Add a=100000 b=100000 -> result=000000, cb=1, overflow=1, zero=1.
- Pulse start again during RUN with different operands -> ignored; first operation's result delivered, single done pulse, previous result held on outputs until that done.
- Drop rst_n for 1 cycle at RUN step 3 -> busy=0, all outputs 0, no done; a new start afterwards completes normally.
- WIDTH=6 with STEP=2 and STEP=3 instances, add a=011111 b=000001 -> result=100000, overflow=1, cb=0; done after 3 and 2 cycles respectively.

Source files
------------

// File: rtl/serial_addsub_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | serial_addsub_unit: LSB-first multi-cycle add/subtract, STEP bits/cycle |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module serial_addsub_unit #(
  parameter int WIDTH = 6,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cb,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cb_q, cb_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic             w_ci;
  logic             w_cmsb;
  logic             w_cout;
  logic [STEP-1:0]  w_sum;
  logic [WIDTH-1:0] w_work_next;
  logic             w_last;

  // Operands shift right each step, so the active slice is always bits [STEP-1:0].
  always_comb begin
    w_ci   = cy_q;
    w_cmsb = 1'b0;
    w_sum  = '0;
    for (int j = 0; j < STEP; j++) begin
      w_cmsb   = w_ci;
      w_sum[j] = a_q[j] ^ b_q[j] ^ w_ci;
      if (mode_q) begin
        w_ci = (a_q[j] & b_q[j]) | ((a_q[j] ^ b_q[j]) & w_ci);
      end else begin
        w_ci = (~a_q[j] & b_q[j]) | (~(a_q[j] ^ b_q[j]) & w_ci);
      end
    end
    w_cout = w_ci;
  end

  // Result bits enter at the top so the word is aligned after the final step.
  if (STEP == WIDTH) begin : g_full
    assign w_work_next = w_sum;
  end else begin : g_shift
    assign w_work_next = {w_sum, work_q[WIDTH-1:STEP]};
  end

  assign w_last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    work_d   = work_q;
    result_d = result_q;
    cb_d     = cb_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          cnt_d   = '0;
          cy_d    = 1'b0;
        end
      end
      S_RUN: begin
        a_d    = a_q >> STEP;
        b_d    = b_q >> STEP;
        cy_d   = w_cout;
        work_d = w_work_next;
        cnt_d  = cnt_q + CW'(1);
        if (w_last) begin
          state_d  = S_DONE;
          cnt_d    = '0;
          result_d = w_work_next;
          cb_d     = w_cout;
          ovf_d    = w_cmsb ^ w_cout;
          zero_d   = (w_work_next == '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      work_q   <= '0;
      result_q <= '0;
      cb_q     <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      work_q   <= work_d;
      result_q <= result_d;
      cb_q     <= cb_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign cb       = cb_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_serial_addsub_unit: scoreboard bench for STEP=1/2/3 instances        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_serial_addsub_unit;

  typedef struct {
    logic       mode;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] res;
    logic       cb;
    logic       ovf;
    logic       zero;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       st;
  logic       mode;
  logic [5:0] a;
  logic [5:0] b;
  int         sel;

  logic       start1, start2, start3;
  logic       busy1, busy2, busy3;
  logic       done1, done2, done3;
  logic [5:0] res1, res2, res3;
  logic       cb1, cb2, cb3;
  logic       ov1, ov2, ov3;
  logic       z1, z2, z3;

  logic       s_busy, s_done, s_cb, s_ov, s_z;
  logic [5:0] s_res;

  int n_cmp;
  int n_err;
  vec_t exp_q[$];
  vec_t tbl[10];
  vec_t v;

  serial_addsub_unit #(.WIDTH(6), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(res1), .cb(cb1), .overflow(ov1), .zero(z1));
  serial_addsub_unit #(.WIDTH(6), .STEP(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode), .a(a), .b(b),
    .busy(busy2), .done(done2), .result(res2), .cb(cb2), .overflow(ov2), .zero(z2));
  serial_addsub_unit #(.WIDTH(6), .STEP(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .mode(mode), .a(a), .b(b),
    .busy(busy3), .done(done3), .result(res3), .cb(cb3), .overflow(ov3), .zero(z3));

  assign start1 = st & (sel == 0);
  assign start2 = st & (sel == 1);
  assign start3 = st & (sel == 2);

  always_comb begin
    s_busy = busy1; s_done = done1; s_res = res1; s_cb = cb1; s_ov = ov1; s_z = z1;
    if (sel == 1) begin
      s_busy = busy2; s_done = done2; s_res = res2; s_cb = cb2; s_ov = ov2; s_z = z2;
    end else if (sel == 2) begin
      s_busy = busy3; s_done = done3; s_res = res3; s_cb = cb3; s_ov = ov3; s_z = z3;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (sel=%0d): got %0h expected %0h", nm, sel, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic md, input logic [5:0] av, input logic [5:0] bv,
                              input logic [5:0] r, input logic c, input logic o, input logic z);
    vec_t t;
    t.mode = md; t.a = av; t.b = bv; t.res = r; t.cb = c; t.ovf = o; t.zero = z;
    return t;
  endfunction

  // One operation on the selected instance; hold_res is what result must show mid-RUN.
  task automatic run_op(input vec_t vin, input int lat_exp, input bit inject,
                        input logic [5:0] hold_res);
    int   lat;
    int   bcnt;
    int   extra;
    vec_t e;
    @(negedge clk);
    mode = vin.mode; a = vin.a; b = vin.b; st = 1'b1;
    exp_q.push_back(vin);
    @(posedge clk); #1;
    st = 1'b0;
    lat = 0; bcnt = 0;
    while (!s_done && lat < 40) begin
      if (s_busy) bcnt++;
      if (lat == 1) chk("hold_result", 32'(s_res), 32'(hold_res));
      if (inject) begin
        st = (lat == 1);
        if (lat == 1) begin a = ~vin.a; b = vin.a; mode = ~vin.mode; end
      end
      @(posedge clk); #1;
      lat++;
    end
    st = 1'b0;
    if (!s_done) chk("done_timeout", 0, 1);
    chk("latency", 32'(lat), 32'(lat_exp));
    chk("busy_cycles", 32'(bcnt), 32'(lat_exp));
    if (exp_q.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("result", 32'(s_res), 32'(e.res));
      chk("cb", 32'(s_cb), 32'(e.cb));
      chk("overflow", 32'(s_ov), 32'(e.ovf));
      chk("zero", 32'(s_z), 32'(e.zero));
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(s_done), 0);
    chk("idle_not_busy", 32'(s_busy), 0);
    if (inject) begin
      extra = 0;
      repeat (lat_exp + 3) begin
        @(posedge clk); #1;
        if (s_done || s_busy) extra++;
      end
      chk("ignored_start", 32'(extra), 0);
    end
  endtask

  initial begin
    int hits;
    n_cmp = 0; n_err = 0;
    sel = 0; st = 1'b0; mode = 1'b0; a = '0; b = '0;
    rst_n = 1'b0;

    tbl[0] = mk(1'b0, 6'b001010, 6'b000100, 6'b000110, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(1'b0, 6'b000001, 6'b000010, 6'b111111, 1'b1, 1'b0, 1'b0);
    tbl[2] = mk(1'b0, 6'b000001, 6'b000001, 6'b000000, 1'b0, 1'b0, 1'b1);
    tbl[3] = mk(1'b0, 6'b100000, 6'b000001, 6'b011111, 1'b0, 1'b1, 1'b0);
    tbl[4] = mk(1'b1, 6'b100000, 6'b100000, 6'b000000, 1'b1, 1'b1, 1'b1);
    tbl[5] = mk(1'b1, 6'b011111, 6'b000001, 6'b100000, 1'b0, 1'b1, 1'b0);
    tbl[6] = mk(1'b1, 6'b000101, 6'b000111, 6'b001100, 1'b0, 1'b0, 1'b0);
    tbl[7] = mk(1'b0, 6'b000000, 6'b100000, 6'b100000, 1'b1, 1'b1, 1'b0);
    tbl[8] = mk(1'b1, 6'b111111, 6'b000001, 6'b000000, 1'b1, 1'b0, 1'b1);
    tbl[9] = mk(1'b0, 6'b101101, 6'b111111, 6'b101110, 1'b1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_result", 32'(res1), 0);
    chk("rst_flags", 32'({cb1, ov1, z1}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // STEP=1 table sweep; each op must hold the previous result during RUN
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i], 6, 1'b0, (i == 0) ? 6'd0 : tbl[i-1].res);
    end

    // Start pulsed mid-RUN with different operands must be ignored
    run_op(tbl[0], 6, 1'b1, tbl[9].res);

    // Reset asserted after RUN step 3 aborts the op
    @(negedge clk);
    mode = 1'b0; a = 6'b001010; b = 6'b000100; st = 1'b1;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_done", 32'(done1), 0);
    chk("abort_result", 32'(res1), 0);
    chk("abort_flags", 32'({cb1, ov1, z1}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hits = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done1 || busy1) hits++;
    end
    chk("abort_no_done", 32'(hits), 0);
    chk("abort_result_after", 32'(res1), 0);
    run_op(tbl[3], 6, 1'b0, 6'd0);

    // STEP=2 instance
    sel = 1;
    run_op(tbl[5], 3, 1'b0, 6'd0);
    run_op(tbl[9], 3, 1'b0, tbl[5].res);
    run_op(tbl[4], 3, 1'b0, tbl[9].res);

    // STEP=3 instance
    sel = 2;
    run_op(tbl[5], 2, 1'b0, 6'd0);
    run_op(tbl[1], 2, 1'b0, tbl[5].res);
    run_op(tbl[3], 2, 1'b0, tbl[1].res);

    if (exp_q.size() != 0) chk("sb_leftover", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
